imem_ctrl: RTL and testbench

//   Parametrised, clocked instruction memory. A host/testbench streams program

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_ram_sp.sv | 34 +++
 rtl/imem_ctrl.sv | 134 +++++++++++++
 tb/tb_imem_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory controller.
package imem_pkg;

   typedef enum logic [1:0] {
      IMEM_IDLE,
      IMEM_LOAD,
      IMEM_RUN
   } imem_state_t;

   // Wide enough for any practical DATA_WIDTH; sliced at the point of use.
   localparam logic [63:0] IMEM_NOP = '0;

endpackage

// File: rtl/imem_ram_sp.sv
// Single-port synchronous RAM with write enable and registered, read-enabled output.
// Only the output register is reset; the array contents survive reset.
module imem_ram_sp #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
   end

   // Output holds between reads so the fetch response stays stable while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= '0;
      end else if (re && !we) begin
         dout <= mem[addr];
      end
   end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory: valid/ready program loader plus a 1-cycle-latency fetch port.
// Optional IMEM_PARITY_EN adds an even-parity bit per word and a fetch_perr output.
module imem_ctrl
   import imem_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_start,
   input  logic                       load_valid,
   input  logic                       load_last,
   input  logic [DATA_WIDTH-1:0]      load_data,
   output logic                       load_ready,
   output logic                       load_err,
   output logic                       loaded,
   output logic [$clog2(DEPTH+1)-1:0] word_count,
   input  logic                       fetch_req,
   input  logic [ADDR_WIDTH-1:0]      fetch_pc,
   output logic                       fetch_valid,
   output logic [DATA_WIDTH-1:0]      fetch_instr,
   output logic                       fetch_err
`ifdef IMEM_PARITY_EN
   ,
   output logic                       fetch_perr
`endif
);

   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int RAM_AW = $clog2(DEPTH);
   localparam int CMP_W  = (ADDR_WIDTH > CNT_W) ? ADDR_WIDTH : CNT_W;
`ifdef IMEM_PARITY_EN
   localparam int RAM_W  = DATA_WIDTH + 1;
`else
   localparam int RAM_W  = DATA_WIDTH;
`endif

   imem_state_t       state_reg;
   logic [CNT_W-1:0]  wr_ptr_reg;
   logic [CNT_W-1:0]  word_count_reg;
   logic              load_ready_reg;
   logic              load_err_reg;
   logic              loaded_reg;
   logic              fetch_valid_reg;
   logic              fetch_err_reg;

   logic              accept;
   logic              ram_full;
   logic              ram_we;
   logic              pc_oob;
   logic [RAM_AW-1:0] ram_addr;
   logic [RAM_W-1:0]  ram_din;
   logic [RAM_W-1:0]  ram_dout;

   // load_start wins over a word offered in the same cycle.
   assign accept   = load_valid && load_ready_reg && !load_start;
   assign ram_full = (wr_ptr_reg == CNT_W'(DEPTH));
   assign ram_we   = accept && !ram_full;
   assign ram_addr = ram_we ? wr_ptr_reg[RAM_AW-1:0] : fetch_pc[RAM_AW-1:0];
   assign pc_oob   = (CMP_W'(fetch_pc) >= CMP_W'(word_count_reg));

`ifdef IMEM_PARITY_EN
   assign ram_din = {^load_data, load_data};
`else
   assign ram_din = load_data;
`endif

   imem_ram_sp #(
      .WIDTH  (RAM_W),
      .DEPTH  (DEPTH),
      .ADDR_W (RAM_AW)
   ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .we   (ram_we),
      .re   (fetch_req),
      .addr (ram_addr),
      .din  (ram_din),
      .dout (ram_dout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IMEM_IDLE;
         wr_ptr_reg      <= '0;
         word_count_reg  <= '0;
         load_ready_reg  <= 1'b0;
         load_err_reg    <= 1'b0;
         loaded_reg      <= 1'b0;
         fetch_valid_reg <= 1'b0;
         fetch_err_reg   <= 1'b0;
      end else begin
         if (load_start) begin
            state_reg      <= IMEM_LOAD;
            wr_ptr_reg     <= '0;
            word_count_reg <= '0;
            load_err_reg   <= 1'b0;
            loaded_reg     <= 1'b0;
            load_ready_reg <= 1'b1;
         end else if (accept) begin
            if (ram_full) begin
               load_err_reg <= 1'b1;
            end else begin
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (load_last) begin
               state_reg      <= IMEM_RUN;
               loaded_reg     <= 1'b1;
               load_ready_reg <= 1'b0;
               word_count_reg <= ram_full ? CNT_W'(DEPTH) : wr_ptr_reg + 1'b1;
            end
         end
         fetch_valid_reg <= fetch_req;
         // Error flag only moves on a request, so outputs hold while idle.
         if (fetch_req) begin
            fetch_err_reg <= (state_reg != IMEM_RUN) || pc_oob;
         end
      end
   end

   assign load_ready  = load_ready_reg;
   assign load_err    = load_err_reg;
   assign loaded      = loaded_reg;
   assign word_count  = word_count_reg;
   assign fetch_valid = fetch_valid_reg;
   assign fetch_err   = fetch_err_reg;
   assign fetch_instr = fetch_err_reg ? IMEM_NOP[DATA_WIDTH-1:0] : ram_dout[DATA_WIDTH-1:0];
`ifdef IMEM_PARITY_EN
   assign fetch_perr  = !fetch_err_reg && (^ram_dout);
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// Scoreboard bench for imem_ctrl (DEPTH=8); parity scenario runs when IMEM_PARITY_EN is defined.
module tb_imem_ctrl;

   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_start = 1'b0;
   logic          load_valid = 1'b0;
   logic          load_last = 1'b0;
   logic [DW-1:0] load_data = '0;
   logic          load_ready;
   logic          load_err;
   logic          loaded;
   logic [CW-1:0] word_count;
   logic          fetch_req = 1'b0;
   logic [AW-1:0] fetch_pc = '0;
   logic          fetch_valid;
   logic [DW-1:0] fetch_instr;
   logic          fetch_err;
   logic          fetch_perr;

   imem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .load_valid  (load_valid),
      .load_last   (load_last),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .load_err    (load_err),
      .loaded      (loaded),
      .word_count  (word_count),
      .fetch_req   (fetch_req),
      .fetch_pc    (fetch_pc),
      .fetch_valid (fetch_valid),
      .fetch_instr (fetch_instr),
      .fetch_err   (fetch_err)
`ifdef IMEM_PARITY_EN
      ,
      .fetch_perr  (fetch_perr)
`endif
   );

`ifndef IMEM_PARITY_EN
   assign fetch_perr = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] pc;
      logic [DW-1:0] instr;
      logic          err;
      logic          perr;
      int            due;
   } exp_t;

   exp_t          sb[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            cyc = 0;
   logic [DW-1:0] last_instr = '0;
   logic          last_err = 1'b0;

   // Reference model of the resident program.
   logic [DW-1:0] m_mem [DEPTH];
   int            m_cnt = 0;
   logic          m_err = 1'b0;
   logic          m_loaded = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: each response must land exactly on its due cycle and match the model.
   always @(negedge clk) begin
      if (rst) begin
         last_instr = '0;
         last_err   = 1'b0;
      end else if (fetch_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got fetch_valid=1 at cycle %0d, required no response", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            $display("fetch pc=%h instr=%h err=%b perr=%b cycle=%0d", e.pc, fetch_instr, fetch_err, fetch_perr, cyc);
            if (e.due != cyc || fetch_err !== e.err || fetch_instr !== e.instr || fetch_perr !== e.perr) begin
               n_err++;
               $display("FAIL fetch_resp pc=%h: got cyc=%0d instr=%h err=%b perr=%b, required cyc=%0d instr=%h err=%b perr=%b",
                        e.pc, cyc, fetch_instr, fetch_err, fetch_perr, e.due, e.instr, e.err, e.perr);
            end
            last_instr = fetch_instr;
            last_err   = fetch_err;
         end
      end else begin
         if (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL fetch_latency pc=%h: got no fetch_valid at cycle %0d, required response", e.pc, cyc);
         end
         n_vec++;
         if (fetch_instr !== last_instr || fetch_err !== last_err) begin
            n_err++;
            $display("FAIL fetch_hold: got instr=%h err=%b, required held instr=%h err=%b",
                     fetch_instr, fetch_err, last_instr, last_err);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_last  = 1'b0;
      fetch_req  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      m_cnt = 0;
      m_err = 1'b0;
      m_loaded = 1'b0;
   endtask

   task automatic start_load(input logic with_valid);
      load_start = 1'b1;
      load_valid = with_valid;
      load_data  = 16'hDEAD;
      tick();
      load_start = 1'b0;
      load_valid = 1'b0;
      m_cnt = 0;
      m_err = 1'b0;
      m_loaded = 1'b0;
   endtask

   task automatic load_word(input logic [DW-1:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      if (m_cnt < DEPTH) begin
         m_mem[m_cnt] = d;
         m_cnt++;
      end else begin
         m_err = 1'b1;
      end
      if (last) m_loaded = 1'b1;
   endtask

   // Issue one request this cycle; expectation comes from the model.
   task automatic fetch(input logic [AW-1:0] pc, input logic exp_perr);
      exp_t e;
      e.pc   = pc;
      e.due  = cyc + 1;
      e.perr = exp_perr;
      if (!m_loaded || int'(pc) >= m_cnt) begin
         e.err   = 1'b1;
         e.instr = '0;
         e.perr  = 1'b0;
      end else begin
         e.err   = 1'b0;
         e.instr = m_mem[pc];
      end
      sb.push_back(e);
      fetch_req = 1'b1;
      fetch_pc  = pc;
      tick();
      fetch_req = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({loaded, load_ready, load_err, fetch_valid, fetch_err} !== 5'b0 || word_count !== '0 || fetch_instr !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got loaded=%b ready=%b lerr=%b fv=%b ferr=%b wc=%0d instr=%h, required all 0",
                  loaded, load_ready, load_err, fetch_valid, fetch_err, word_count, fetch_instr);
      end
      fetch(16'h0000, 1'b0);
      idle(2);
   endtask

   task automatic test_load_fetch();
      start_load(1'b0);
      n_vec++;
      if (load_ready !== 1'b1) begin
         n_err++;
         $display("FAIL load_ready_in_load: got %b, required 1", load_ready);
      end
      load_word(16'h1111, 1'b0);
      load_word(16'h2222, 1'b0);
      load_word(16'h3333, 1'b0);
      load_word(16'h4444, 1'b1);
      n_vec++;
      if (loaded !== 1'b1 || word_count !== CW'(4) || load_ready !== 1'b0 || load_err !== 1'b0) begin
         n_err++;
         $display("FAIL load4_status: got loaded=%b wc=%0d ready=%b lerr=%b, required 1 4 0 0",
                  loaded, word_count, load_ready, load_err);
      end
      for (int i = 0; i < 4; i++) fetch(AW'(i), 1'b0);
      idle(2);
      fetch(16'h0002, 1'b0);
      idle(1);
   endtask

   task automatic test_out_of_range();
      fetch(16'h0004, 1'b0);
      fetch(16'hFFFF, 1'b0);
      fetch(16'h0008, 1'b0);
      fetch(16'h0100, 1'b0);
      fetch(16'h0003, 1'b0);
      idle(2);
   endtask

   task automatic test_overflow();
      start_load(1'b0);
      for (int i = 0; i < 10; i++) load_word(16'hA000 + DW'(i), (i == 9));
      n_vec++;
      if (load_err !== 1'b1 || word_count !== CW'(DEPTH) || loaded !== 1'b1) begin
         n_err++;
         $display("FAIL overflow_status: got lerr=%b wc=%0d loaded=%b, required 1 %0d 1",
                  load_err, word_count, loaded, DEPTH);
      end
      for (int i = 0; i <= DEPTH; i++) fetch(AW'(i), 1'b0);
      idle(2);
   endtask

   task automatic test_restart();
      start_load(1'b0);
      load_word(16'hBAD0, 1'b0);
      load_word(16'hBAD1, 1'b0);
      fetch(16'h0000, 1'b0);
      start_load(1'b1);
      load_word(16'h0C01, 1'b0);
      load_word(16'h0C02, 1'b0);
      n_vec++;
      if (loaded !== 1'b0 || load_ready !== 1'b1) begin
         n_err++;
         $display("FAIL midload_status: got loaded=%b ready=%b, required 0 1", loaded, load_ready);
      end
      load_word(16'h0C03, 1'b1);
      n_vec++;
      if (word_count !== CW'(3) || load_err !== 1'b0 || loaded !== 1'b1) begin
         n_err++;
         $display("FAIL restart_status: got wc=%0d lerr=%b loaded=%b, required 3 0 1",
                  word_count, load_err, loaded);
      end
      for (int i = 0; i < 4; i++) fetch(AW'(i), 1'b0);
      idle(2);
      start_load(1'b0);
      load_word(16'h5555, 1'b0);
      idle(1);
      do_reset();
      n_vec++;
      if (loaded !== 1'b0 || word_count !== '0 || load_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rst_midload: got loaded=%b wc=%0d ready=%b, required 0 0 0", loaded, word_count, load_ready);
      end
      fetch(16'h0000, 1'b0);
      fetch(16'h0001, 1'b0);
      idle(2);
   endtask

`ifdef IMEM_PARITY_EN
   task automatic test_parity();
      start_load(1'b0);
      load_word(16'h0F0F, 1'b0);
      load_word(16'h1234, 1'b0);
      load_word(16'h8001, 1'b1);
      dut.u_ram.mem[1][0] = ~dut.u_ram.mem[1][0];
      m_mem[1] = 16'h1235;
      fetch(16'h0001, 1'b1);
      fetch(16'h0000, 1'b0);
      fetch(16'h0002, 1'b0);
      idle(2);
   endtask
`endif

   initial begin
      test_reset();
      test_load_fetch();
      test_out_of_range();
      test_overflow();
      test_restart();
`ifdef IMEM_PARITY_EN
      test_parity();
`endif
      idle(2);
      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL pending_responses: got %0d outstanding, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by time limit, required finish");
      $fatal(1, "timeout");
   end

endmodule
